// File: rtl/serial_tx.sv
// Buffered 8N1 RS-232 transmitter: a byte FIFO fed by a valid/ready push port,
// drained by a frame FSM paced by a fractional baud accumulator.
module serial_tx #(
  parameter int CLK_FREQUENCY = 25000000,
  parameter int BAUD          = 115200,
  parameter int ACC_WIDTH     = 16,
  parameter int FIFO_DEPTH    = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [7:0]                    tx_data,
  input  logic                          tx_valid,
  output logic                          tx_ready,
  output logic                          TxD,
  output logic                          tx_busy,
  output logic                          tx_idle,
  output logic                          tx_done,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam longint INC_WIDE =
    ((longint'(BAUD) << (ACC_WIDTH - 4)) + longint'(CLK_FREQUENCY >> 5)) /
    longint'(CLK_FREQUENCY >> 4);
  localparam logic [ACC_WIDTH-1:0] INC       = ACC_WIDTH'(INC_WIDE);
  localparam logic [CNT_W-1:0]     FIFO_FULL = CNT_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } txState_t;

  txState_t             state;
  txState_t             stateNext;
  logic [ACC_WIDTH-1:0] acc;
  logic [ACC_WIDTH-1:0] accNext;
  logic [ACC_WIDTH:0]   accSum;
  logic                 baudTick;
  logic [7:0]           shiftReg;
  logic [7:0]           shiftNext;
  logic [2:0]           bitIdx;
  logic [2:0]           bitIdxNext;
  logic                 txNext;
  logic                 doneNext;
  logic                 popByte;
  logic                 pushByte;
  logic [7:0]           headByte;
  logic [7:0]           fifoMem [FIFO_DEPTH];
  logic [PTR_W-1:0]     wrPtr;
  logic [PTR_W-1:0]     rdPtr;
  logic [CNT_W-1:0]     countNext;

  assign tx_ready = (fifo_count != FIFO_FULL);
  assign pushByte = tx_valid && tx_ready;
  assign headByte = fifoMem[rdPtr];

  // Baud accumulator step; parked at zero in IDLE so each frame starts phase-aligned.
  always_comb begin
    accSum   = {1'b0, acc} + {1'b0, INC};
    accNext  = {ACC_WIDTH{1'b0}};
    baudTick = 1'b0;
    if (state != IDLE) begin
      accNext  = accSum[ACC_WIDTH-1:0];
      baudTick = accSum[ACC_WIDTH];
    end else begin
      accNext  = {ACC_WIDTH{1'b0}};
      baudTick = 1'b0;
    end
  end

  // Frame sequencing: next state, shifter, line level, and FIFO pop request.
  always_comb begin
    stateNext  = state;
    shiftNext  = shiftReg;
    bitIdxNext = bitIdx;
    txNext     = 1'b1;
    doneNext   = 1'b0;
    popByte    = 1'b0;
    case (state)
      IDLE: begin
        if (fifo_count != {CNT_W{1'b0}}) begin
          popByte   = 1'b1;
          shiftNext = headByte;
          stateNext = START;
          txNext    = 1'b0;
        end else begin
          txNext = 1'b1;
        end
      end
      START: begin
        if (baudTick) begin
          stateNext  = DATA;
          bitIdxNext = 3'd0;
          txNext     = shiftReg[0];
        end else begin
          txNext = 1'b0;
        end
      end
      DATA: begin
        if (baudTick) begin
          shiftNext = {1'b0, shiftReg[7:1]};
          if (bitIdx == 3'd7) begin
            stateNext = STOP;
            txNext    = 1'b1;
          end else begin
            bitIdxNext = bitIdx + 3'd1;
            txNext     = shiftReg[1];
          end
        end else begin
          txNext = shiftReg[0];
        end
      end
      STOP: begin
        if (baudTick) begin
          doneNext = 1'b1;
          // Chain straight into the next start bit when more data is queued.
          if (fifo_count != {CNT_W{1'b0}}) begin
            popByte   = 1'b1;
            shiftNext = headByte;
            stateNext = START;
            txNext    = 1'b0;
          end else begin
            stateNext = IDLE;
            txNext    = 1'b1;
          end
        end else begin
          txNext = 1'b1;
        end
      end
      default: begin
        stateNext = IDLE;
        txNext    = 1'b1;
      end
    endcase
  end

  // FIFO occupancy: simultaneous push and pop leave the count unchanged.
  always_comb begin
    countNext = fifo_count;
    case ({pushByte, popByte})
      2'b10:   countNext = fifo_count + {{(CNT_W-1){1'b0}}, 1'b1};
      2'b01:   countNext = fifo_count - {{(CNT_W-1){1'b0}}, 1'b1};
      default: countNext = fifo_count;
    endcase
  end

  // FIFO storage write port.
  always_ff @(posedge clk) begin
    if (pushByte) begin
      fifoMem[wrPtr] <= tx_data;
    end
  end

  // FIFO pointers and fill level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wrPtr      <= {PTR_W{1'b0}};
      rdPtr      <= {PTR_W{1'b0}};
      fifo_count <= {CNT_W{1'b0}};
    end else begin
      if (pushByte) begin
        wrPtr <= wrPtr + {{(PTR_W-1){1'b0}}, 1'b1};
      end
      if (popByte) begin
        rdPtr <= rdPtr + {{(PTR_W-1){1'b0}}, 1'b1};
      end
      fifo_count <= countNext;
    end
  end

  // Frame state, baud phase and shifter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      acc      <= {ACC_WIDTH{1'b0}};
      shiftReg <= 8'h00;
      bitIdx   <= 3'd0;
    end else begin
      state    <= stateNext;
      acc      <= accNext;
      shiftReg <= shiftNext;
      bitIdx   <= bitIdxNext;
    end
  end

  // Registered outputs, loaded from next-state values so they track the state edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      TxD     <= 1'b1;
      tx_done <= 1'b0;
      tx_busy <= 1'b0;
      tx_idle <= 1'b1;
    end else begin
      TxD     <= txNext;
      tx_done <= doneNext;
      tx_busy <= (stateNext != IDLE);
      tx_idle <= (stateNext == IDLE) && (countNext == {CNT_W{1'b0}});
    end
  end

endmodule

// File: tb/tb_serial_tx.sv
// Scoreboard bench for serial_tx: a line-level reference model predicts every TxD
// cycle, FIFO occupancy and tx_done; a second instance checks default-rate bit timing.
module tb_serial_tx;

  localparam int DEPTH  = 8;
  localparam int BITLEN = 16;
  localparam int FRAME  = 10 * BITLEN;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready, TxD, tx_busy, tx_idle, tx_done;
  logic [3:0] fifo_count;

  logic [7:0] bData = 8'h00;
  logic       bValid = 1'b0;
  logic       bReady, bTxD, bBusy, bIdle, bDone;
  logic [3:0] bCount;

  int nChecks = 0;
  int nFail   = 0;

  serial_tx #(.CLK_FREQUENCY(1600000), .BAUD(100000), .ACC_WIDTH(16), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .TxD(TxD), .tx_busy(tx_busy), .tx_idle(tx_idle), .tx_done(tx_done), .fifo_count(fifo_count)
  );

  serial_tx dutB (
    .clk(clk), .rst_n(rst_n), .tx_data(bData), .tx_valid(bValid), .tx_ready(bReady),
    .TxD(bTxD), .tx_busy(bBusy), .tx_idle(bIdle), .tx_done(bDone), .fifo_count(bCount)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    nChecks++;
    if (act != exp) begin
      nFail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
    end
  endtask

  task automatic chkRange(input string name, input int act, input int lo, input int hi);
    nChecks++;
    if (act < lo || act > hi) begin
      nFail++;
      $display("FAIL %s: got %0d, expected %0d..%0d at %0t", name, act, lo, hi, $time);
    end
  endtask

  // Reference model state for instance A
  logic [7:0] expQ[$];
  logic [7:0] curByte = 8'h00;
  int  modelCount = 0, prevCount = 0, pendPush = 0, fc = 0;
  int  framesSeen = 0, donesSeen = 0, accepted = 0;
  bit  inFrame = 1'b0, doneDue = 1'b0;

  // Line-level monitor for A: predicts every cycle of TxD from the scoreboard queue.
  always @(negedge clk) begin
    bit wasIn, ended, startExp, startObs, doneExp;
    int k, expBit;
    if (!rst_n) begin
      expQ.delete();
      modelCount = 0; prevCount = 0; pendPush = 0; fc = 0;
      inFrame = 1'b0; doneDue = 1'b0;
    end else begin
      modelCount += pendPush;
      pendPush = 0;
      doneExp = doneDue;
      doneDue = 1'b0;
      wasIn = inFrame;
      ended = 1'b0;
      if (inFrame) begin
        fc++;
        if (fc == FRAME) begin
          inFrame = 1'b0;
          ended = 1'b1;
        end
      end
      startExp = (!wasIn || ended) && (prevCount > 0);
      startObs = !inFrame && (TxD == 1'b0);
      chk("start_bit_timing", int'(startObs), int'(startExp));
      if (startObs) begin
        inFrame = 1'b1;
        fc = 0;
        framesSeen++;
        if (expQ.size() > 0) begin
          curByte = expQ.pop_front();
          modelCount--;
        end
      end
      if (inFrame) begin
        k = fc / BITLEN;
        if (k == 0)      expBit = 0;
        else if (k == 9) expBit = 1;
        else             expBit = int'(curByte[k-1]);
        chk("txd_frame_bit", int'(TxD), expBit);
        if (fc == FRAME - 1) doneDue = 1'b1;
      end else begin
        chk("txd_idle_high", int'(TxD), 1);
      end
      chk("tx_done", int'(tx_done), int'(doneExp));
      if (tx_done) donesSeen++;
      chk("tx_busy", int'(tx_busy), int'(inFrame));
      chk("tx_idle", int'(tx_idle), int'(!inFrame && modelCount == 0));
      chk("fifo_count", int'(fifo_count), modelCount);
      chk("tx_ready", int'(tx_ready), int'(modelCount < DEPTH));
      prevCount = modelCount;
      if (tx_valid && modelCount < DEPTH) begin
        expQ.push_back(tx_data);
        pendPush = 1;
        accepted++;
      end
    end
  end

  // Bit-period monitor for B (default rate), fed with 0x55 so every bit toggles the line.
  int bCyc = 0, bLast = 0, bFall = 0, bEdges = 0, bFrames = 0;
  bit bActive = 1'b0;
  logic bPrev = 1'b1;
  always @(negedge clk) begin
    if (!rst_n) begin
      bActive = 1'b0; bPrev = 1'b1; bEdges = 0;
    end else begin
      bCyc++;
      if (bTxD !== bPrev) begin
        if (bActive) begin
          chkRange("b_bit_period", bCyc - bLast, 216, 218);
        end else if (bTxD == 1'b0) begin
          bActive = 1'b1;
          bFall = bCyc;
          bEdges = 0;
        end
        bLast = bCyc;
        bEdges++;
        bPrev = bTxD;
      end
      if (bDone) begin
        chk("b_done_in_frame", int'(bActive), 1);
        chkRange("b_stop_period", bCyc - bLast, 216, 218);
        chkRange("b_frame_span", bCyc - bFall, 2169, 2171);
        chk("b_line_edges", bEdges, 10);
        bActive = 1'b0;
        bFrames++;
      end
    end
  end

  task automatic pushBurst(input logic [7:0] first, input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      tx_valid = 1'b1;
      tx_data  = first + 8'(i);
    end
    @(posedge clk); #1;
    tx_valid = 1'b0;
  endtask

  task automatic drainA(input int maxCycles);
    int n = 0;
    while ((inFrame || modelCount != 0 || pendPush != 0) && n < maxCycles) begin
      @(posedge clk);
      n++;
    end
    chk("drain_within_budget", int'(n < maxCycles), 1);
    repeat (4) @(posedge clk);
    #1;
  endtask

  initial begin
    int f0, d0, a0, n;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_txd", int'(TxD), 1);
    chk("reset_busy", int'(tx_busy), 0);
    chk("reset_idle", int'(tx_idle), 1);
    chk("reset_done", int'(tx_done), 0);
    chk("reset_ready", int'(tx_ready), 1);
    chk("reset_count", int'(fifo_count), 0);
    rst_n = 1'b1;
    repeat (5) @(posedge clk);

    // single 0xA5 frame
    f0 = framesSeen; d0 = donesSeen;
    pushBurst(8'hA5, 1);
    drainA(400);
    chk("a5_frames", framesSeen - f0, 1);
    chk("a5_dones", donesSeen - d0, 1);

    // three back-to-back frames
    f0 = framesSeen; d0 = donesSeen;
    @(posedge clk); #1; tx_valid = 1'b1; tx_data = 8'h00;
    @(posedge clk); #1; tx_data = 8'hFF;
    @(posedge clk); #1; tx_data = 8'h55;
    @(posedge clk); #1; tx_valid = 1'b0;
    drainA(700);
    chk("b2b_frames", framesSeen - f0, 3);
    chk("b2b_dones", donesSeen - d0, 3);

    // 12-cycle burst into an 8-deep FIFO: 9 accepted, 3 dropped
    f0 = framesSeen; d0 = donesSeen;
    pushBurst(8'h10, 12);
    drainA(1800);
    chk("overflow_frames", framesSeen - f0, 9);
    chk("overflow_dones", donesSeen - d0, 9);

    // valid held across the first pop while full: rejected at the pop edge, accepted after
    f0 = framesSeen;
    pushBurst(8'h60, 200);
    drainA(2000);
    chk("full_pop_frames", framesSeen - f0, 10);

    // random traffic
    f0 = framesSeen; a0 = accepted;
    for (int i = 0; i < 500; i++) begin
      @(posedge clk); #1;
      tx_valid = ($urandom_range(0, 19) < 2);
      tx_data  = 8'($urandom);
    end
    @(posedge clk); #1; tx_valid = 1'b0;
    drainA(2000);
    chk("random_frames", framesSeen - f0, accepted - a0);

    // reset during data bit 3 with two bytes queued
    d0 = donesSeen;
    pushBurst(8'h81, 3);
    repeat (70) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("midreset_txd", int'(TxD), 1);
    chk("midreset_count", int'(fifo_count), 0);
    chk("midreset_busy", int'(tx_busy), 0);
    chk("midreset_ready", int'(tx_ready), 1);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    f0 = framesSeen;
    repeat (400) @(posedge clk);
    chk("midreset_no_frames", framesSeen - f0, 0);
    chk("midreset_no_done", donesSeen - d0, 0);
    pushBurst(8'h3C, 1);
    drainA(400);
    chk("post_reset_frames", framesSeen - f0, 1);
    chk("post_reset_dones", donesSeen - d0, 1);

    // default-rate instance timing
    @(posedge clk); #1; bValid = 1'b1; bData = 8'h55;
    @(posedge clk); #1; bValid = 1'b0;
    n = 0;
    while (bFrames == 0 && n < 3000) begin
      @(posedge clk);
      n++;
    end
    chk("b_frame_completed", bFrames, 1);
    repeat (4) @(posedge clk);
    chk("b_idle_after", int'(bIdle), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule
